// File: rtl/data_mem_responder.sv
// Handshaked word load/store responder for a little-endian data segment.
// Accepts one access at a time, responds LATENCY cycles later, and flags misaligned or out-of-range addresses.
module data_mem_responder #(
    parameter int unsigned BYTES   = 1024,
    parameter logic [31:0] START   = 32'h1000_8000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(BYTES);
    localparam int          CW       = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [31:0] LAST_OFF = 32'(BYTES - 4);
    localparam bit          DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          wr_p0;
    logic [31:0]   addr_p0;
    logic [31:0]   wdata_p0;

    logic [7:0]    mem [BYTES];

    logic          accept;
    logic          do_access;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [31:0]   acc_off;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;

    // Stage p0: request capture; a single-cycle responder uses the live request instead.
    always_comb begin
        accept    = req_valid && (state == IDLE);
        acc_write = DIRECT ? req_write : wr_p0;
        acc_addr  = DIRECT ? req_addr  : addr_p0;
        acc_wdata = DIRECT ? req_wdata : wdata_p0;
        do_access = DIRECT ? accept : ((state == WAIT) && (cnt == '0));
        acc_off   = acc_addr - START;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_off > LAST_OFF);
        idx       = acc_off[AW-1:0];
        rd_word   = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= req_write;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // Stage p1: the access commits on the edge that enters RESP, never earlier.
    always_ff @(posedge clk) begin
        if (do_access && acc_write && !acc_err) begin
            mem[idx]           <= acc_wdata[7:0];
            mem[idx + AW'(1)]  <= acc_wdata[15:8];
            mem[idx + AW'(2)]  <= acc_wdata[23:16];
            mem[idx + AW'(3)]  <= acc_wdata[31:24];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (DIRECT) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase

            if (do_access) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_write) ? 32'd0 : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: three instances (LATENCY 2, 4, 1) checked against a byte-array memory model.
module tb_data_mem_responder;

    localparam int unsigned BYTES = 1024;
    localparam logic [31:0] START = 32'h1000_8000;
    localparam int          LAT [3] = '{2, 4, 1};

    logic        clk;
    logic        rstn       [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    logic [7:0]  mem_m [3][BYTES];
    int          n_checks;
    int          n_errors;

    data_mem_responder #(.BYTES(BYTES), .START(START), .LATENCY(2)) u_lat2 (
        .clk(clk), .rstn(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.BYTES(BYTES), .START(START), .LATENCY(4)) u_lat4 (
        .clk(clk), .rstn(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_responder #(.BYTES(BYTES), .START(START), .LATENCY(1)) u_lat1 (
        .clk(clk), .rstn(rstn[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Error rule evaluated on wide signed arithmetic, so addresses below START are simply negative offsets.
    function automatic bit model_err(input logic [31:0] addr);
        longint off;
        off = longint'(addr) - longint'(START);
        return (addr % 4 != 0) || (off < 0) || (off > longint'(BYTES) - 4);
    endfunction

    // One full access on DUT d, starting and ending on a negative clock edge.
    task automatic xact(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int bp, input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        int          off;
        exp_err = model_err(addr);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            off = int'(addr - START);
            if (wr) begin
                for (int k = 0; k < 4; k++) mem_m[d][off + k] = wd[8*k +: 8];
            end else begin
                exp_rd = {mem_m[d][off + 3], mem_m[d][off + 2], mem_m[d][off + 1], mem_m[d][off]};
            end
        end
        check({tag, "/req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        resp_ready[d] = (bp == 0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 0;
        while (!resp_valid[d] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, "/latency"}, 32'(n), 32'(LAT[d] - 1));
        check({tag, "/rdata"}, resp_rdata[d], exp_rd);
        check({tag, "/err"}, 32'(resp_err[d]), 32'(exp_err));
        if (bp > 0) begin
            req_valid[d] = 1'b1;
            req_write[d] = 1'b1;
            req_addr[d]  = START + 32'(4 * $urandom_range(0, BYTES / 4 - 1));
            req_wdata[d] = $urandom;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check({tag, "/bp_valid"}, 32'(resp_valid[d]), 32'd1);
                check({tag, "/bp_rdata"}, resp_rdata[d], exp_rd);
                check({tag, "/bp_err"}, 32'(resp_err[d]), 32'(exp_err));
                check({tag, "/bp_ready"}, 32'(req_ready[d]), 32'd0);
            end
            resp_ready[d] = 1'b1;
            req_valid[d]  = 1'b0;
        end
        @(negedge clk);
        check({tag, "/post_valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "/post_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "/post_rdata"}, resp_rdata[d], exp_rd);
        check({tag, "/post_err"}, 32'(resp_err[d]), 32'(exp_err));
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return START + 32'(4 * $urandom_range(0, BYTES / 4 - 1)) + 32'($urandom_range(1, 3));
            1:       return START - 32'(4 * $urandom_range(1, 64));
            2:       return START + BYTES + 32'(4 * $urandom_range(0, 64));
            3:       return START + BYTES - 4;
            default: return START + 32'(4 * $urandom_range(0, BYTES / 4 - 1));
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int d = 0; d < 3; d++) begin
            rstn[d]       = 1'b0;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            resp_ready[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset/req_ready", 32'(req_ready[d]), 32'd1);
            check("reset/resp_valid", 32'(resp_valid[d]), 32'd0);
            check("reset/resp_rdata", resp_rdata[d], 32'd0);
            check("reset/resp_err", 32'(resp_err[d]), 32'd0);
        end

        // Contents are not cleared by reset, so give every word a known value first.
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < BYTES / 4; w++) begin
                xact(d, 1'b1, START + 32'(4 * w), $urandom, 0, "init");
            end
        end

        xact(0, 1'b1, 32'h1000_8004, 32'hDEAD_BEEF, 0, "store_beef");
        xact(0, 1'b0, 32'h1000_8004, 32'd0, 0, "load_beef");
        check("load_beef/byte0", 32'(resp_rdata[0][7:0]), 32'h0000_00EF);
        xact(0, 1'b1, 32'h1000_8002, 32'hCAFE_F00D, 0, "store_misaligned");
        xact(0, 1'b0, 32'h1000_8000, 32'd0, 0, "load_after_misaligned");
        xact(0, 1'b0, 32'h1000_7FFC, 32'd0, 0, "load_below");
        xact(0, 1'b0, 32'h1000_8400, 32'd0, 0, "load_above");
        xact(0, 1'b0, 32'h1000_83FC, 32'd0, 0, "load_last");
        xact(0, 1'b0, 32'h1000_8004, 32'd0, 5, "backpressure");
        xact(0, 1'b0, 32'h1000_8004, 32'd0, 0, "after_bp");

        // Reset in the middle of a LATENCY=4 store must drop it.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h1000_8010;
        req_wdata[1] = 32'h1234_5678;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rstn[1] = 1'b0;
        #1;
        check("wait_reset/req_ready", 32'(req_ready[1]), 32'd1);
        check("wait_reset/resp_valid", 32'(resp_valid[1]), 32'd0);
        check("wait_reset/resp_rdata", resp_rdata[1], 32'd0);
        check("wait_reset/resp_err", 32'(resp_err[1]), 32'd0);
        @(negedge clk);
        rstn[1] = 1'b1;
        repeat (4) @(negedge clk);
        check("wait_reset/idle_valid", 32'(resp_valid[1]), 32'd0);
        xact(1, 1'b0, 32'h1000_8010, 32'd0, 0, "wait_reset/load");

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 60; i++) begin
                xact(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
